aurora_rx_aligner: RTL and testbench
====================================

# aurora_rx_aligner

Receive-side word aligner for the Aurora 8b/10b link. It takes one serial bit per lane per clock, as produced by serialising the per-lane 10-bit encoder output of the transmit top. It hunts for K28.5 comma sequences, locks a 10-bit symbol boundary per lane, and emits aligned 10-bit symbols to the downstream 8b/10b decoders. It also reports per-lane and channel-wide alignment status.

## Interface
- `LANES`, default `` `MAX_LINKS ``: number of lanes.
- `ALIGN_CNT`, default 3: boundary-aligned commas needed to lock, range 1..15.
- `LOSS_CNT`, default 4: consecutive misaligned commas that drop lock, range 1..15.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `lane_enable` input LANES: lane participates when 1.
- `serial_in` input LANES: one received bit per lane per cycle; the first-transmitted bit (a) arrives first.
- `symbol_out` output [LANES][10]: aligned symbol; bit 0 is the first-received bit (a), bit 9 is j.
- `symbol_valid` output LANES: one-cycle strobe per aligned symbol.
- `comma_det` output LANES: strobe when the emitted symbol is a comma.
- `aligned` output LANES: lane is in LOCKED.
- `all_aligned` output 1: every enabled lane is aligned and at least one lane is enabled.
- `err_cnt` output [LANES][8]: present only with the macro described under Configuration.

## Operation
- Per lane, a 10-bit shift window: `win_next = {serial_in, win[9:1]}`, updated every cycle while the lane is enabled.
- Comma test (combinational on `win_next`): `win_next[6:0]` equals `COMMA_P` (7'b1111100) or `COMMA_N` (7'b0000011).
- A 4-bit bit counter `bcnt` (0..9) marks symbol boundaries. A boundary is the shift on which `bcnt == 9`; `bcnt` wraps to 0 on that shift.
- State HUNT:
  - `symbol_valid = 0`.
  - On a comma: `bcnt <= 0`, emit `win_next` as a symbol, set `good <= 1`.
  - Go to LOCKED if `ALIGN_CNT == 1`, otherwise go to CHECK.
- State CHECK:
  - Emit `win_next` at each boundary.
  - Comma at a boundary: `good++`. Go to LOCKED when `good` reaches `ALIGN_CNT`.
  - Comma off-boundary: restart as a HUNT detection (realign, `good <= 1`).
  - Non-comma symbols at boundaries are emitted and leave `good` unchanged.
- State LOCKED:
  - Emit `win_next` at each boundary.
  - Comma at a boundary: `bad <= 0`.
  - Comma off-boundary: `bad++`, no realign. When `bad` reaches `LOSS_CNT`, go to HUNT; `aligned` drops.
- When an off-boundary comma and a boundary coincide, they cannot both occur on the same shift; a boundary comma always wins.
- When `lane_enable` is 0:
  - The lane is forced to HUNT.
  - `win`, `bcnt`, `good` and `bad` are cleared.
  - All lane outputs are 0 the next cycle.
- `all_aligned = |lane_enable && &(aligned | ~lane_enable)`, combinational from registers.

## Timing
- Reset: all outputs, state and counters are 0; all lanes are in HUNT.
- Latency: the last bit of a symbol sampled on edge N appears on `symbol_out`, `symbol_valid` and `comma_det` after edge N+1, i.e. one register stage.
- Boundary spacing: after alignment, `symbol_valid` pulses exactly every 10 cycles.
- `aligned` rises in the same cycle as the `symbol_valid` of the `ALIGN_CNT`-th aligned comma.
- `aligned` falls in the same cycle as the `LOSS_CNT`-th misaligned comma would have been seen on the outputs.
- `symbol_out` holds its value between strobes.
- Asserting `rst` mid-symbol clears everything immediately; there is no partial output.

## Configuration
- Macro `AURORA_RX_ERR_CNT_EN`.
- Defined:
  - Adds the `err_cnt` port.
  - Per-lane 8-bit counter incremented on every off-boundary comma in CHECK or LOCKED, and on every LOCKED-to-HUNT transition. A simultaneous event counts once.
  - The counter saturates at 255 and clears on `rst` or when `lane_enable` is 0.
- Undefined: the port and logic are absent; the rest of the behaviour is identical.

## Structure
- Additions to `aurora_pkg`:
  - `COMMA_P` and `COMMA_N`.
  - `` `SYMBOL_SIZE `` (10, equal to `` `ENCODER_DATA_OUT_SIZE ``).
  - `rx_align_state_e {HUNT, CHECK, LOCKED}`.
- Sub-module `aurora_rx_lane_aligner`: one lane containing the window, counters and FSM.
- The top instantiates `LANES` copies in a generate loop and forms `all_aligned`.

## Test plan
- Reset: assert `rst` mid-stream. Require all outputs 0 asynchronously and all lanes in HUNT after release.
- Lock on lane 0 (`ALIGN_CNT = 3`):
  - Stimulus: 3 random bits, then repeated K28.5 RD− (bit order a..j 0011111010).
  - First `symbol_valid` one cycle after bit 13, with `symbol_out = 10'h17C`.
  - `aligned[0]` is 1 one cycle after bit 33.
- Data after lock:
  - Stimulus: D21.5 symbols (1010101010 in bit order a..j).
  - `symbol_out = 10'h155` every 10 cycles, `comma_det = 0`, `aligned` stays 1.
- Bit slip in LOCKED (`LOSS_CNT = 4`):
  - Stimulus: insert one extra bit, then continue K28.5.
  - `aligned` stays 1 through 3 misaligned commas and drops on the 4th.
  - `aligned` returns after 3 more commas at the new phase.
- Lane disable:
  - With 4 lanes locked and `all_aligned = 1`, deassert `lane_enable[2]`.
  - Next cycle `aligned[2] = 0` and `symbol_valid[2] = 0`; `all_aligned` stays 1.
  - With all lanes disabled, `all_aligned = 0`.
- With `AURORA_RX_ERR_CNT_EN`:
  - Stimulus: 300 slip-induced off-boundary commas.
  - `err_cnt` saturates at 255 and clears when `lane_enable` is 0.

Source files
------------

// File: rtl/aurora_pkg.sv
// rtl/aurora_pkg.sv - shared Aurora constants and types used by the rx word aligner
`ifndef ENCODER_DATA_OUT_SIZE
`define ENCODER_DATA_OUT_SIZE 10
`endif
`ifndef SYMBOL_SIZE
`define SYMBOL_SIZE `ENCODER_DATA_OUT_SIZE
`endif
`ifndef MAX_LINKS
`define MAX_LINKS 4
`endif

package aurora_pkg;

  localparam int SYMBOL_W = `SYMBOL_SIZE;

  // K28.5 comma prefix (bits a..g, bit 0 = a) for both running disparities
  localparam logic [6:0] COMMA_P = 7'b1111100;
  localparam logic [6:0] COMMA_N = 7'b0000011;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } rx_align_state_e;

  function automatic logic is_comma(input logic [6:0] w);
    return (w == COMMA_P) || (w == COMMA_N);
  endfunction

endpackage

// File: rtl/aurora_rx_lane_aligner.sv
// rtl/aurora_rx_lane_aligner.sv - one-lane comma hunter and symbol aligner (err_cnt with AURORA_RX_ERR_CNT_EN)
module aurora_rx_lane_aligner
  import aurora_pkg::*;
#(
  parameter int ALIGN_CNT = 3,
  parameter int LOSS_CNT  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable_i,
  input  logic                serial_i,
  output logic [SYMBOL_W-1:0] symbol_o,
  output logic                valid_o,
  output logic                comma_o,
  output logic                aligned_o
`ifdef AURORA_RX_ERR_CNT_EN
  ,
  output logic [7:0]          err_cnt_o
`endif
);

  localparam logic [4:0] ALIGN_L = 5'(ALIGN_CNT);
  localparam logic [4:0] LOSS_L  = 5'(LOSS_CNT);

  // The window register keeps the 9 most recent bits; the incoming bit completes it.
  logic [SYMBOL_W-2:0] win_q, win_d;
  logic [SYMBOL_W-1:0] shift;
  logic [3:0]          bcnt_q, bcnt_d;
  logic [3:0]          good_q, good_d;
  logic [3:0]          bad_q, bad_d;
  rx_align_state_e     state_q, state_d;
  logic [SYMBOL_W-1:0] sym_q;
  logic                valid_q, comma_q;
  logic                comma, boundary, emit, realign;

  // Next-state logic: window shift, boundary counter and alignment FSM
  always_comb begin
    shift    = {serial_i, win_q};
    comma    = is_comma(shift[6:0]);
    boundary = (bcnt_q == 4'd9);
    win_d    = shift[SYMBOL_W-1:1];
    bcnt_d   = boundary ? 4'd0 : bcnt_q + 4'd1;
    state_d  = state_q;
    good_d   = good_q;
    bad_d    = bad_q;
    emit     = 1'b0;
    realign  = 1'b0;
    case (state_q)
      HUNT: begin
        if (comma) realign = 1'b1;
      end
      CHECK: begin
        if (boundary) begin
          emit = 1'b1;
          if (comma) begin
            good_d = good_q + 4'd1;
            if (({1'b0, good_q} + 5'd1) >= ALIGN_L) begin
              state_d = LOCKED;
              bad_d   = 4'd0;
            end
          end
        end else if (comma) begin
          realign = 1'b1;
        end
      end
      LOCKED: begin
        if (boundary) begin
          emit = 1'b1;
          if (comma) bad_d = 4'd0;
        end else if (comma) begin
          // Slipped comma: tolerate up to LOSS_CNT-1 before giving up lock
          if (({1'b0, bad_q} + 5'd1) >= LOSS_L) begin
            state_d = HUNT;
            bad_d   = 4'd0;
            good_d  = 4'd0;
          end else begin
            bad_d = bad_q + 4'd1;
          end
        end
      end
      default: state_d = HUNT;
    endcase
    if (realign) begin
      emit    = 1'b1;
      bcnt_d  = 4'd0;
      good_d  = 4'd1;
      bad_d   = 4'd0;
      state_d = (ALIGN_CNT == 1) ? LOCKED : CHECK;
    end
    if (!enable_i) begin
      win_d   = '0;
      bcnt_d  = 4'd0;
      good_d  = 4'd0;
      bad_d   = 4'd0;
      state_d = HUNT;
      emit    = 1'b0;
    end
  end

  // Window, counters and FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q   <= '0;
      bcnt_q  <= 4'd0;
      good_q  <= 4'd0;
      bad_q   <= 4'd0;
      state_q <= HUNT;
    end else begin
      win_q   <= win_d;
      bcnt_q  <= bcnt_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      state_q <= state_d;
    end
  end

  // Output register: symbol holds between strobes, cleared while the lane is off
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_q   <= '0;
      valid_q <= 1'b0;
      comma_q <= 1'b0;
    end else begin
      valid_q <= emit;
      comma_q <= emit && comma;
      if (!enable_i) sym_q <= '0;
      else if (emit) sym_q <= shift;
    end
  end

  assign symbol_o  = sym_q;
  assign valid_o   = valid_q;
  assign comma_o   = comma_q;
  assign aligned_o = (state_q == LOCKED);

`ifdef AURORA_RX_ERR_CNT_EN
  logic [7:0] err_q;
  logic       err_evt;

  // Every off-boundary comma outside HUNT; the LOCKED->HUNT drop is one of these
  assign err_evt = enable_i && comma && !boundary && (state_q != HUNT);

  // Saturating alignment error counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 8'd0;
    else if (!enable_i) err_q <= 8'd0;
    else if (err_evt && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
  end

  assign err_cnt_o = err_q;
`endif

endmodule

// File: rtl/aurora_rx_aligner.sv
// rtl/aurora_rx_aligner.sv - multi-lane rx word aligner top (err_cnt port with AURORA_RX_ERR_CNT_EN)
`ifndef MAX_LINKS
`define MAX_LINKS 4
`endif

module aurora_rx_aligner
  import aurora_pkg::*;
#(
  parameter int LANES     = `MAX_LINKS,
  parameter int ALIGN_CNT = 3,
  parameter int LOSS_CNT  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [LANES-1:0]               lane_enable,
  input  logic [LANES-1:0]               serial_in,
  output logic [LANES-1:0][SYMBOL_W-1:0] symbol_out,
  output logic [LANES-1:0]               symbol_valid,
  output logic [LANES-1:0]               comma_det,
  output logic [LANES-1:0]               aligned,
  output logic                           all_aligned
`ifdef AURORA_RX_ERR_CNT_EN
  ,
  output logic [LANES-1:0][7:0]          err_cnt
`endif
);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    aurora_rx_lane_aligner #(
      .ALIGN_CNT(ALIGN_CNT),
      .LOSS_CNT (LOSS_CNT)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .enable_i (lane_enable[g]),
      .serial_i (serial_in[g]),
      .symbol_o (symbol_out[g]),
      .valid_o  (symbol_valid[g]),
      .comma_o  (comma_det[g]),
      .aligned_o(aligned[g])
`ifdef AURORA_RX_ERR_CNT_EN
      ,
      .err_cnt_o(err_cnt[g])
`endif
    );
  end

  // Disabled lanes are ignored, but an all-off channel is never aligned
  assign all_aligned = (|lane_enable) && (&(aligned | ~lane_enable));

endmodule

// File: tb/tb_aurora_rx_aligner.sv
// tb/tb_aurora_rx_aligner.sv - directed self-checking bench for aurora_rx_aligner (AURORA_RX_ERR_CNT_EN adds err_cnt test)
`timescale 1ns/1ps
module tb_aurora_rx_aligner;

  localparam logic [9:0] K_SYM = 10'h17C;  // K28.5 RD-, a..j = 0011111010
  localparam logic [9:0] D_SYM = 10'h155;  // D21.5,     a..j = 1010101010

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       lane_enable = 4'b0000;
  logic [3:0]       serial_in = 4'b0000;
  logic [3:0][9:0]  symbol_out;
  logic [3:0]       symbol_valid;
  logic [3:0]       comma_det;
  logic [3:0]       aligned;
  logic             all_aligned;
`ifdef AURORA_RX_ERR_CNT_EN
  logic [3:0][7:0]  err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  aurora_rx_aligner #(.LANES(4), .ALIGN_CNT(3), .LOSS_CNT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .lane_enable (lane_enable),
    .serial_in   (serial_in),
    .symbol_out  (symbol_out),
    .symbol_valid(symbol_valid),
    .comma_det   (comma_det),
    .aligned     (aligned),
    .all_aligned (all_aligned)
`ifdef AURORA_RX_ERR_CNT_EN
    ,
    .err_cnt     (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step(input logic b);
    serial_in = {4{b}};
    @(posedge clk);
    #1;
  endtask

  task automatic send_k();
    for (int i = 0; i < 10; i++) step(K_SYM[i]);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (symbol_valid !== 4'b0000) begin errors++; $display("FAIL rst_valid got %b want 0000", symbol_valid); end
    checks++; if (aligned !== 4'b0000) begin errors++; $display("FAIL rst_aligned got %b want 0000", aligned); end
    checks++; if (all_aligned !== 1'b0) begin errors++; $display("FAIL rst_all_aligned got %b want 0", all_aligned); end
    checks++; if (symbol_out !== 40'd0) begin errors++; $display("FAIL rst_symbol got %h want 0", symbol_out); end
    rst = 1'b0;
  endtask

  task automatic test_lock();
    lane_enable = 4'b0001;
    step(1'b1); step(1'b0); step(1'b1);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 10; i++) begin
        step(K_SYM[i]);
        if (i == 8) begin
          checks++; if (symbol_valid[0] !== 1'b0) begin errors++; $display("FAIL lock_midsym_valid k=%0d got %b want 0", k, symbol_valid[0]); end
        end
      end
      checks++; if (symbol_valid[0] !== 1'b1) begin errors++; $display("FAIL lock_valid k=%0d got %b want 1", k, symbol_valid[0]); end
      checks++; if (symbol_out[0] !== 10'h17C) begin errors++; $display("FAIL lock_symbol k=%0d got %h want 17c", k, symbol_out[0]); end
      checks++; if (comma_det[0] !== 1'b1) begin errors++; $display("FAIL lock_comma k=%0d got %b want 1", k, comma_det[0]); end
      checks++; if (aligned[0] !== (k == 2)) begin errors++; $display("FAIL lock_aligned k=%0d got %b want %b", k, aligned[0], (k == 2)); end
    end
    checks++; if (all_aligned !== 1'b1) begin errors++; $display("FAIL lock_all_aligned got %b want 1", all_aligned); end
  endtask

  task automatic test_data();
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 10; i++) begin
        step(D_SYM[i]);
        if (i == 4) begin
          checks++; if (symbol_valid[0] !== 1'b0) begin errors++; $display("FAIL data_midsym_valid d=%0d got %b want 0", d, symbol_valid[0]); end
          checks++; if (symbol_out[0] !== ((d == 0) ? 10'h17C : 10'h155)) begin errors++; $display("FAIL data_hold d=%0d got %h", d, symbol_out[0]); end
        end
      end
      checks++; if (symbol_valid[0] !== 1'b1) begin errors++; $display("FAIL data_valid d=%0d got %b want 1", d, symbol_valid[0]); end
      checks++; if (symbol_out[0] !== 10'h155) begin errors++; $display("FAIL data_symbol d=%0d got %h want 155", d, symbol_out[0]); end
      checks++; if (comma_det[0] !== 1'b0) begin errors++; $display("FAIL data_comma d=%0d got %b want 0", d, comma_det[0]); end
      checks++; if (aligned[0] !== 1'b1) begin errors++; $display("FAIL data_aligned d=%0d got %b want 1", d, aligned[0]); end
    end
  endtask

  task automatic test_slip();
    step(1'b0);
    for (int c = 0; c < 4; c++) begin
      send_k();
      checks++; if (symbol_valid[0] !== 1'b0) begin errors++; $display("FAIL slip_valid c=%0d got %b want 0", c, symbol_valid[0]); end
      checks++; if (aligned[0] !== (c < 3)) begin errors++; $display("FAIL slip_aligned c=%0d got %b want %b", c, aligned[0], (c < 3)); end
    end
    for (int c = 0; c < 3; c++) begin
      send_k();
      checks++; if (symbol_valid[0] !== 1'b1) begin errors++; $display("FAIL relock_valid c=%0d got %b want 1", c, symbol_valid[0]); end
      checks++; if (symbol_out[0] !== 10'h17C) begin errors++; $display("FAIL relock_symbol c=%0d got %h want 17c", c, symbol_out[0]); end
      checks++; if (aligned[0] !== (c == 2)) begin errors++; $display("FAIL relock_aligned c=%0d got %b want %b", c, aligned[0], (c == 2)); end
    end
  endtask

  task automatic test_disable();
    lane_enable = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      send_k();
      checks++; if (symbol_valid !== 4'b1111) begin errors++; $display("FAIL dis_valid c=%0d got %b want 1111", c, symbol_valid); end
    end
    checks++; if (aligned !== 4'b1111) begin errors++; $display("FAIL dis_aligned_all got %b want 1111", aligned); end
    checks++; if (all_aligned !== 1'b1) begin errors++; $display("FAIL dis_all_aligned got %b want 1", all_aligned); end
    for (int i = 0; i < 9; i++) step(K_SYM[i]);
    lane_enable = 4'b1011;
    step(K_SYM[9]);
    checks++; if (symbol_valid !== 4'b1011) begin errors++; $display("FAIL dis_lane2_valid got %b want 1011", symbol_valid); end
    checks++; if (aligned !== 4'b1011) begin errors++; $display("FAIL dis_lane2_aligned got %b want 1011", aligned); end
    checks++; if (all_aligned !== 1'b1) begin errors++; $display("FAIL dis_lane2_all got %b want 1", all_aligned); end
    checks++; if (symbol_out[2] !== 10'h000) begin errors++; $display("FAIL dis_lane2_symbol got %h want 000", symbol_out[2]); end
    checks++; if (symbol_out[1] !== 10'h17C) begin errors++; $display("FAIL dis_lane1_symbol got %h want 17c", symbol_out[1]); end
    lane_enable = 4'b0000;
    step(1'b0);
    checks++; if (all_aligned !== 1'b0) begin errors++; $display("FAIL dis_none_all got %b want 0", all_aligned); end
    checks++; if (aligned !== 4'b0000) begin errors++; $display("FAIL dis_none_aligned got %b want 0000", aligned); end
  endtask

  task automatic test_reset_mid();
    lane_enable = 4'b1111;
    for (int c = 0; c < 3; c++) send_k();
    checks++; if (aligned !== 4'b1111) begin errors++; $display("FAIL rmid_pre_aligned got %b want 1111", aligned); end
    for (int i = 0; i < 4; i++) step(K_SYM[i]);
    #2 rst = 1'b1;
    #1;
    checks++; if (aligned !== 4'b0000) begin errors++; $display("FAIL rmid_aligned got %b want 0000", aligned); end
    checks++; if (symbol_out !== 40'd0) begin errors++; $display("FAIL rmid_symbol got %h want 0", symbol_out); end
    checks++; if (all_aligned !== 1'b0) begin errors++; $display("FAIL rmid_all got %b want 0", all_aligned); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send_k();
    checks++; if (symbol_valid !== 4'b1111) begin errors++; $display("FAIL rmid_hunt_valid got %b want 1111", symbol_valid); end
    checks++; if (comma_det !== 4'b1111) begin errors++; $display("FAIL rmid_hunt_comma got %b want 1111", comma_det); end
    checks++; if (aligned !== 4'b0000) begin errors++; $display("FAIL rmid_hunt_aligned got %b want 0000", aligned); end
  endtask

`ifdef AURORA_RX_ERR_CNT_EN
  task automatic test_err_cnt();
    lane_enable = 4'b0000;
    step(1'b0);
    lane_enable = 4'b0001;
    for (int c = 0; c < 3; c++) send_k();
    checks++; if (aligned[0] !== 1'b1) begin errors++; $display("FAIL err_lock got %b want 1", aligned[0]); end
    checks++; if (err_cnt[0] !== 8'd0) begin errors++; $display("FAIL err_start got %0d want 0", err_cnt[0]); end
    for (int n = 1; n <= 300; n++) begin
      step(1'b0);
      send_k();
      if (n == 10) begin
        checks++; if (err_cnt[0] !== 8'd9) begin errors++; $display("FAIL err_mid got %0d want 9", err_cnt[0]); end
      end
    end
    checks++; if (err_cnt[0] !== 8'd255) begin errors++; $display("FAIL err_sat got %0d want 255", err_cnt[0]); end
    lane_enable = 4'b0000;
    step(1'b0);
    checks++; if (err_cnt[0] !== 8'd0) begin errors++; $display("FAIL err_clear got %0d want 0", err_cnt[0]); end
  endtask
`endif

  initial begin
    test_reset();
    test_lock();
    test_data();
    test_slip();
    test_disable();
    test_reset_mid();
`ifdef AURORA_RX_ERR_CNT_EN
    test_err_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
